tx_ppdu_sequencer: RTL and testbench
====================================

TX_PPDU_SEQUENCER -- requirements
Module: tx_ppdu_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port Start, input, 1: one-cycle frame request; sampled only in IDLE.
REQ-004 SHALL have port Rate, input, 4: RATE code R1..R4 (R1 = bit 3); captured with Start.
REQ-005 SHALL have port Length, input, 12: PSDU length in octets; captured with Start.
REQ-006 SHALL have port Seed, input, 7: scrambler initial state; captured with Start.
REQ-007 SHALL have port Mac_Data, input, 1: serial PSDU bit, LSB of each octet first.
REQ-008 SHALL have port Mac_Valid, input, 1: Mac_Data is valid.
REQ-009 SHALL have port Mac_Ready, output, 1: PSDU bit is consumed when Mac_Valid && Mac_Ready.
REQ-010 SHALL have port Out, output, 1: serial bit to encoder.
REQ-011 SHALL have port Out_Valid, output, 1: Out is valid.
REQ-012 SHALL have port Out_Ready, input, 1: bit is transferred when Out_Valid && Out_Ready.
REQ-013 SHALL have port Busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port Done, output, 1: one-cycle pulse after the last bit of a frame is transferred.
REQ-015 SHALL have port Error, output, 1: one-cycle pulse when a request is rejected.

Function
REQ-016 States SHALL be IDLE, CALC, SIGNAL, SERVICE, PAYLOAD, TAIL, PAD, DONE.
REQ-017 IDLE: Start captures Rate, Length and Seed and moves to CALC; Start in any other state SHALL be ignored.
REQ-018 CALC: Rate SHALL map to N_DBPS:
- 1101 = 24, 1111 = 36, 0101 = 48, 0111 = 72
- 1001 = 96, 1011 = 144, 0001 = 192, 0011 = 216
- Any other code, or Length = 0, SHALL pulse Error and return to IDLE; no bit is output.
REQ-019 CALC SHALL compute by iterative subtraction, one step per cycle:
- N_BITS = 22 + 8*Length, 16-bit arithmetic.
- N_SYM = ceil(N_BITS / N_DBPS).
- N_PAD = N_SYM*N_DBPS - N_BITS.
- CALC SHALL end in at most 1400 cycles and then go to SIGNAL.
REQ-020 SIGNAL SHALL send 24 bits, unscrambled, in this order:
- Rate R1..R4, then a reserved 0.
- Length, LSB first, 12 bits.
- Even parity over the first 17 bits.
- Six 0 bits.
REQ-021 At SIGNAL entry, the scrambler SHALL load Seed; Seed = 0 SHALL be replaced by 7'b1011101.
REQ-022 SERVICE SHALL send 16 zero bits, scrambled.
REQ-023 PAYLOAD SHALL send 8*Length MAC bits, scrambled.
- Mac_Ready = Out_Ready, and only in PAYLOAD.
- Out_Valid = Mac_Valid in PAYLOAD.
REQ-024 TAIL SHALL output 6 zero bits.
- The scrambler SHALL advance during TAIL.
- Its output SHALL be forced to 0 (tail after scrambling).
REQ-025 PAD SHALL send N_PAD zero bits, scrambled; N_PAD = 0 SHALL skip PAD.
REQ-026 DONE SHALL pulse Done for one cycle and return to IDLE.
REQ-027 The scrambler SHALL advance only on a transferred bit in SERVICE, PAYLOAD, TAIL or PAD.
- It SHALL use x^7 + x^4 + 1: feedback = s[6]^s[3]; scrambled bit = data ^ feedback.
REQ-028 Out_Valid SHALL be 1 throughout SIGNAL, SERVICE, TAIL and PAD.
- While Out_Ready = 0, Out and Out_Valid SHALL hold.
- Bit counters SHALL advance only on a transfer.
REQ-029 Phase boundaries SHALL be seamless.
- A transfer on the last bit of a phase SHALL present the first bit of the next phase in the following cycle.
- No Out_Valid gap is allowed except for a PAYLOAD stall.
REQ-030 Total bits transferred per frame SHALL equal 24 + N_SYM*N_DBPS.

Reset
REQ-031 While Reset = 0, the block SHALL be held as follows:
- State = IDLE; LFSR = 7'b0; all counters = 0.
- Out, Out_Valid, Mac_Ready, Busy, Done, Error = 0.
REQ-032 Reset asserted mid-frame SHALL abort immediately; no Done or Error pulse follows deassertion.

Structure
REQ-033 A shared package SHALL hold:
- The state enumeration and the rate-to-N_DBPS table.
- Constants SIGNAL_BITS = 24, SERVICE_BITS = 16, TAIL_BITS = 6 and DEFAULT_SEED = 7'b1011101.
REQ-034 The LFSR SHALL be one sub-module, tx_scrambler_lfsr, with ports:
- Clk, Reset, Load, Seed, Advance, Data_In, Data_Out.

Verification
REQ-035 Rate = 1101, Length = 1, Seed = 1011101, Out_Ready = 1:
- SIGNAL = 1,1,0,1,0, then 1 followed by 11 zeros, parity 0, then 000000.
- N_SYM = 2, N_PAD = 18; 72 bits total; Done once.
REQ-036 Rate = 0011, Length = 100:
- N_SYM = 4, N_PAD = 42; 888 bits total.
- SERVICE/PAYLOAD/PAD match the reference LFSR model; the 6 TAIL bits are all 0.
REQ-037 Rate = 0000 or Length = 0 -> one Error pulse, Out_Valid never 1, back in IDLE.
REQ-038 Random Out_Ready and Mac_Valid stalls on Length = 16 -> bit stream identical to the no-stall run, and Out held stable during each stall.
REQ-039 Reset deasserted then reasserted after 40 transferred bits -> all outputs 0 immediately. A new Start then produces a correct frame from SIGNAL bit 0.
REQ-040 Start pulsed while Busy -> ignored; the current frame completes unchanged.

Source files
------------

// File: rtl/tx_ppdu_sequencer_pkg.sv
// Shared types and constants for the 802.11a-style PPDU bit sequencer.
package tx_ppdu_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        SIGNAL,
        SERVICE,
        PAYLOAD,
        TAIL,
        PAD,
        DONE
    } state_t;

    localparam int SIGNAL_BITS  = 24;
    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;
    localparam logic [6:0] DEFAULT_SEED = 7'b1011101;

    // Data bits per OFDM symbol; 0 marks an unsupported RATE code.
    function automatic logic [7:0] rate_to_ndbps(input logic [3:0] rate);
        case (rate)
            4'b1101: return 8'd24;
            4'b1111: return 8'd36;
            4'b0101: return 8'd48;
            4'b0111: return 8'd72;
            4'b1001: return 8'd96;
            4'b1011: return 8'd144;
            4'b0001: return 8'd192;
            4'b0011: return 8'd216;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/tx_scrambler_lfsr.sv
// Frame-synchronous x^7 + x^4 + 1 scrambler; output is combinational on the current state.
module tx_scrambler_lfsr (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic [6:0] Seed,
    input  logic       Advance,
    input  logic       Data_In,
    output logic       Data_Out
);

    logic [6:0] lfsr;
    logic       feedback;

    assign feedback = lfsr[6] ^ lfsr[3];
    assign Data_Out = Data_In ^ feedback;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lfsr <= 7'd0;
        end else if (Load) begin
            lfsr <= Seed;
        end else if (Advance) begin
            lfsr <= {lfsr[5:0], feedback};
        end
    end

endmodule

// File: rtl/tx_ppdu_sequencer.sv
// Serialises SIGNAL, SERVICE, PSDU, TAIL and PAD bits of one PPDU with valid/ready flow control.
module tx_ppdu_sequencer
    import tx_ppdu_sequencer_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  Rate,
    input  logic [11:0] Length,
    input  logic [6:0]  Seed,
    input  logic        Mac_Data,
    input  logic        Mac_Valid,
    output logic        Mac_Ready,
    output logic        Out,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    state_t      state, state_nxt;
    logic [3:0]  rate_r;
    logic [11:0] len_r;
    logic [6:0]  seed_r;
    logic [15:0] rem_r;
    logic [15:0] npad_r;
    logic [15:0] bit_cnt;

    logic [7:0]  ndbps;
    logic [15:0] phase_len;
    logic        last_bit;
    logic        xfer;
    logic        calc_fail;
    logic        calc_last;
    logic [23:0] sig_word;

    logic        lfsr_load;
    logic        lfsr_adv;
    logic        lfsr_din;
    logic        lfsr_dout;
    logic [6:0]  lfsr_seed;

    assign ndbps     = rate_to_ndbps(rate_r);
    assign calc_fail = (ndbps == 8'd0) || (len_r == 12'd0);
    assign calc_last = (rem_r <= {8'd0, ndbps});

    // Bit i of sig_word is the i-th SIGNAL bit on the wire.
    assign sig_word = {6'b0, ^{rate_r, len_r}, len_r, 1'b0,
                       rate_r[0], rate_r[1], rate_r[2], rate_r[3]};

    assign Out_Valid = (state == SIGNAL) || (state == SERVICE) || (state == TAIL) ||
                       (state == PAD) || ((state == PAYLOAD) && Mac_Valid);
    assign xfer      = Out_Valid && Out_Ready;
    assign Busy      = (state != IDLE);

    assign lfsr_seed = (seed_r == 7'd0) ? DEFAULT_SEED : seed_r;
    assign lfsr_din  = (state == PAYLOAD) ? Mac_Data : 1'b0;
    assign lfsr_adv  = xfer && ((state == SERVICE) || (state == PAYLOAD) ||
                                (state == TAIL) || (state == PAD));

    always_comb begin
        case (state)
            SIGNAL:  phase_len = 16'(SIGNAL_BITS);
            SERVICE: phase_len = 16'(SERVICE_BITS);
            PAYLOAD: phase_len = {1'b0, len_r, 3'b000};
            TAIL:    phase_len = 16'(TAIL_BITS);
            PAD:     phase_len = npad_r;
            default: phase_len = 16'd0;
        endcase
    end

    assign last_bit = (bit_cnt == phase_len - 16'd1);

    tx_scrambler_lfsr u_scrambler (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (lfsr_load),
        .Seed     (lfsr_seed),
        .Advance  (lfsr_adv),
        .Data_In  (lfsr_din),
        .Data_Out (lfsr_dout)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            rate_r  <= 4'd0;
            len_r   <= 12'd0;
            seed_r  <= 7'd0;
            rem_r   <= 16'd0;
            npad_r  <= 16'd0;
            bit_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && Start) begin
                rate_r <= Rate;
                len_r  <= Length;
                seed_r <= Seed;
                rem_r  <= 16'd22 + {1'b0, Length, 3'b000};
            end
            // Division by repeated subtraction: the final remainder gives the pad count.
            if (state == CALC && !calc_fail) begin
                if (calc_last) begin
                    npad_r <= {8'd0, ndbps} - rem_r;
                end else begin
                    rem_r <= rem_r - {8'd0, ndbps};
                end
            end
            if (state == IDLE || state == CALC || state == DONE) begin
                bit_cnt <= 16'd0;
            end else if (xfer) begin
                bit_cnt <= last_bit ? 16'd0 : bit_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        Out       = 1'b0;
        Mac_Ready = 1'b0;
        Done      = 1'b0;
        Error     = 1'b0;
        lfsr_load = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_nxt = CALC;
            end
            CALC: begin
                if (calc_fail) begin
                    Error     = 1'b1;
                    state_nxt = IDLE;
                end else if (calc_last) begin
                    lfsr_load = 1'b1;
                    state_nxt = SIGNAL;
                end
            end
            SIGNAL: begin
                Out = sig_word[bit_cnt[4:0]];
                if (xfer && last_bit) state_nxt = SERVICE;
            end
            SERVICE: begin
                Out = lfsr_dout;
                if (xfer && last_bit) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                Out       = lfsr_dout;
                Mac_Ready = Out_Ready;
                if (xfer && last_bit) state_nxt = TAIL;
            end
            TAIL: begin
                // Scrambler keeps stepping but the tail leaves the block as zeros.
                Out = 1'b0;
                if (xfer && last_bit) state_nxt = (npad_r == 16'd0) ? DONE : PAD;
            end
            PAD: begin
                Out = lfsr_dout;
                if (xfer && last_bit) state_nxt = DONE;
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_ppdu_sequencer.sv
// Directed bench for tx_ppdu_sequencer with a reference scrambler/frame model.
module tb_tx_ppdu_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [3:0]  Rate;
    logic [11:0] Length;
    logic [6:0]  Seed;
    logic        Mac_Data;
    logic        Mac_Valid;
    logic        Mac_Ready;
    logic        Out;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Busy;
    logic        Done;
    logic        Error;

    int checks = 0;
    int errors = 0;

    logic got[$];
    logic exp_q[$];
    logic ref_q[$];
    int   done_cnt, err_cnt, ov_cnt, hold_bad, mac_idx;
    bit   timed_out;

    tx_ppdu_sequencer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Rate      (Rate),
        .Length    (Length),
        .Seed      (Seed),
        .Mac_Data  (Mac_Data),
        .Mac_Valid (Mac_Valid),
        .Mac_Ready (Mac_Ready),
        .Out       (Out),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mac_byte(input int i);
        return 8'((i * 29 + 7) & 255);
    endfunction

    function automatic int count_diff(input int n);
        int d = 0;
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic build_expected(input logic [3:0] r, input logic [11:0] l, input logic [6:0] s);
        int nd, nbits, nsym, npad;
        logic [6:0] ml;
        logic [7:0] b;
        logic fb;
        exp_q.delete();
        case (r)
            4'b1101: nd = 24;
            4'b1111: nd = 36;
            4'b0101: nd = 48;
            4'b0111: nd = 72;
            4'b1001: nd = 96;
            4'b1011: nd = 144;
            4'b0001: nd = 192;
            4'b0011: nd = 216;
            default: nd = 1;
        endcase
        nbits = 22 + 8 * int'(l);
        nsym  = (nbits + nd - 1) / nd;
        npad  = nsym * nd - nbits;
        for (int i = 0; i < 4; i++) exp_q.push_back(r[3-i]);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 12; i++) exp_q.push_back(l[i]);
        exp_q.push_back(^{r, l});
        for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
        ml = (s == 7'd0) ? 7'h5D : s;
        for (int i = 0; i < 16; i++) begin
            fb = ml[6] ^ ml[3]; ml = {ml[5:0], fb}; exp_q.push_back(fb);
        end
        for (int k = 0; k < 8 * int'(l); k++) begin
            b = mac_byte(k / 8);
            fb = ml[6] ^ ml[3]; ml = {ml[5:0], fb}; exp_q.push_back(b[k%8] ^ fb);
        end
        for (int i = 0; i < 6; i++) begin
            fb = ml[6] ^ ml[3]; ml = {ml[5:0], fb}; exp_q.push_back(1'b0);
        end
        for (int i = 0; i < npad; i++) begin
            fb = ml[6] ^ ml[3]; ml = {ml[5:0], fb}; exp_q.push_back(fb);
        end
    endtask

    // Issues Start at a negedge, then plays MAC and sink until the frame ends (plus 4 cycles).
    task automatic run_frame(input logic [3:0] r, input logic [11:0] l, input logic [6:0] s,
                             input bit stall, input int abort_at, input bit poke_start);
        int tail = 0;
        bit ended = 0;
        logic prev_ov = 0, prev_or = 1, prev_out = 0, prev_mv = 0, prev_mr = 0;
        logic [7:0] b;
        got.delete();
        done_cnt = 0; err_cnt = 0; ov_cnt = 0; hold_bad = 0; mac_idx = 0; timed_out = 0;
        @(negedge Clk);
        Start = 1'b1; Rate = r; Length = l; Seed = s;
        Mac_Valid = 1'b0; Out_Ready = 1'b1;
        @(negedge Clk);
        for (int cyc = 0; cyc < 20000 && tail < 4; cyc++) begin
            Start = poke_start && (cyc == 60);
            if (Start) begin
                Rate = 4'b0011; Length = 12'd50; Seed = 7'd3;
            end
            if (stall) begin
                Out_Ready = ($urandom_range(3, 0) != 0);
                if (!(prev_mv && !prev_mr)) Mac_Valid = ($urandom_range(3, 0) != 0);
            end else begin
                Out_Ready = 1'b1;
                Mac_Valid = 1'b1;
            end
            b = mac_byte(mac_idx / 8);
            Mac_Data = (mac_idx < 8 * int'(l)) ? b[mac_idx%8] : 1'b0;
            #1;
            if (prev_ov && !prev_or && !(Out_Valid && Out == prev_out)) hold_bad++;
            if (Out_Valid) ov_cnt++;
            if (Done) done_cnt++;
            if (Error) err_cnt++;
            if (Out_Valid && Out_Ready) got.push_back(Out);
            if (Mac_Valid && Mac_Ready) mac_idx++;
            prev_ov = Out_Valid; prev_or = Out_Ready; prev_out = Out;
            prev_mv = Mac_Valid; prev_mr = Mac_Ready;
            if (Done || Error) ended = 1;
            if (ended) tail++;
            if (abort_at > 0 && got.size() == abort_at) break;
            @(negedge Clk);
        end
        if (!ended && abort_at == 0) timed_out = 1;
    endtask

    initial begin
        logic [23:0] sig;
        logic        tailv;
        int          quiet;
        Reset = 1'b1; Start = 1'b0; Rate = 4'd0; Length = 12'd0; Seed = 7'd0;
        Mac_Data = 1'b0; Mac_Valid = 1'b0; Out_Ready = 1'b1;
        #2 Reset = 1'b0;
        #3;
        check("reset_outputs", {26'd0, Out, Out_Valid, Mac_Ready, Busy, Done, Error}, 32'd0);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;

        // Frame A: 6 Mb/s, one octet, Start re-pulsed mid-frame
        run_frame(4'b1101, 12'd1, 7'b1011101, 0, 0, 1);
        build_expected(4'b1101, 12'd1, 7'b1011101);
        check("a_timeout", timed_out, 0);
        check("a_total_bits", got.size(), 72);
        for (int i = 0; i < 24; i++) sig[i] = (i < got.size()) ? got[i] : 1'bx;
        check("a_signal", sig, 24'h00002B);
        check("a_bits_vs_model", count_diff((got.size() < 72) ? got.size() : 72), 0);
        check("a_done_pulses", done_cnt, 1);
        check("a_error_pulses", err_cnt, 0);
        check("a_busy_after", Busy, 0);

        // Frame B: 54 Mb/s, 100 octets
        run_frame(4'b0011, 12'd100, 7'b0101010, 0, 0, 0);
        build_expected(4'b0011, 12'd100, 7'b0101010);
        check("b_timeout", timed_out, 0);
        check("b_total_bits", got.size(), 888);
        check("b_bits_vs_model", count_diff((got.size() < 888) ? got.size() : 888), 0);
        tailv = 1'b1;
        if (got.size() >= 846) begin
            tailv = 1'b0;
            for (int i = 840; i < 846; i++) tailv = tailv | got[i];
        end
        check("b_tail_zero", tailv, 0);
        check("b_done_pulses", done_cnt, 1);

        // Rejected requests
        run_frame(4'b0000, 12'd5, 7'd1, 0, 0, 0);
        check("badrate_error", err_cnt, 1);
        check("badrate_out_valid", ov_cnt, 0);
        check("badrate_busy", Busy, 0);
        run_frame(4'b1101, 12'd0, 7'd1, 0, 0, 0);
        check("zerolen_error", err_cnt, 1);
        check("zerolen_out_valid", ov_cnt, 0);
        check("zerolen_busy", Busy, 0);

        // Length 16 without, then with, random stalls
        run_frame(4'b1011, 12'd16, 7'b1100011, 0, 0, 0);
        build_expected(4'b1011, 12'd16, 7'b1100011);
        check("ns_timeout", timed_out, 0);
        check("ns_total_bits", got.size(), 312);
        check("ns_bits_vs_model", count_diff((got.size() < 312) ? got.size() : 312), 0);
        ref_q = got;
        run_frame(4'b1011, 12'd16, 7'b1100011, 1, 0, 0);
        check("st_timeout", timed_out, 0);
        check("st_total_bits", got.size(), 312);
        exp_q = ref_q;
        check("st_same_as_nostall", count_diff((got.size() < ref_q.size()) ? got.size() : ref_q.size()), 0);
        check("st_hold_during_stall", hold_bad, 0);
        check("st_done_pulses", done_cnt, 1);

        // Reset after 40 transferred bits, then a clean frame with the default seed
        run_frame(4'b0101, 12'd20, 7'd0, 0, 40, 0);
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("abort_outputs", {26'd0, Out, Out_Valid, Mac_Ready, Busy, Done, Error}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1; Mac_Valid = 1'b0;
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            #1;
            if (Done || Error || Busy) quiet++;
        end
        check("abort_no_pulse", quiet, 0);
        run_frame(4'b0101, 12'd20, 7'd0, 0, 0, 0);
        build_expected(4'b0101, 12'd20, 7'd0);
        check("re_timeout", timed_out, 0);
        check("re_total_bits", got.size(), 216);
        check("re_bits_vs_model", count_diff((got.size() < 216) ? got.size() : 216), 0);
        check("re_done_pulses", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
